// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Byte-serial instruction fetch for an 8-bit CPU with a 16-bit address space.
// Each instruction byte takes one ADDR cycle and one DATA cycle. The first
// byte (the opcode) is shown to an external decoder through raw_opcode. The
// decoder's answer (op_len) sets how many more bytes to fetch. The assembled
// instruction is held in VALID until the execute stage accepts it.
//
// Ports
//   clk           system clock, all state changes on its rising edge
//   reset         synchronous, active-high reset
//   mem_addr      byte address to ROM/RAM (always the current pc)
//   mem_rd_en     read strobe; memory answers on mem_data_in one cycle later
//   mem_data_in   read data from memory
//   raw_opcode    opcode byte presented to the decoder
//   op_len        decoder result: instruction length 1..3 (0 is taken as 1)
//   instr_valid   assembled instruction is available
//   instr_ready   execute stage accepts the instruction
//   opcode/operand_lo/operand_hi  assembled instruction bytes
//   target_addr   {operand_hi, operand_lo}
//   next_pc       address of the byte after the assembled instruction
//   pc_load       one-cycle redirect request, pc_load_addr is the new pc
//   halt_req      enter HALT; only reset leaves it
//   halted        block is in HALT
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [15:0] RESET_VECTOR = 16'hF000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [7:0]  mem_data_in,
    output logic [7:0]  raw_opcode,
    input  logic [1:0]  op_len,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  opcode,
    output logic [7:0]  operand_lo,
    output logic [7:0]  operand_hi,
    output logic [15:0] target_addr,
    output logic [15:0] next_pc,
    input  logic        pc_load,
    input  logic [15:0] pc_load_addr,
    input  logic        halt_req,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_ADDR  = 2'd0,
        ST_DATA  = 2'd1,
        ST_VALID = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t      state_r;
    logic [15:0] pc_r;
    logic [1:0]  byte_idx_r;
    logic [1:0]  len_r;
    logic [7:0]  opcode_r;
    logic [7:0]  operand_lo_r;
    logic [7:0]  operand_hi_r;

    logic [1:0]  len_in_s;
    logic [1:0]  eff_len_s;
    logic        last_byte_s;
    logic        opcode_cycle_s;

    // Opcode byte is arriving this cycle: the decoder must see it directly
    // from memory so op_len is ready to be latched at the same edge.
    assign opcode_cycle_s = (state_r == ST_DATA) && (byte_idx_r == 2'd0);

    // A zero length from the decoder is treated as a 1-byte instruction.
    assign len_in_s = (op_len == 2'd0) ? 2'd1 : op_len;

    // Length is not latched yet while the opcode byte is being captured,
    // so the decoder's live answer is used for that first byte.
    assign eff_len_s   = (byte_idx_r == 2'd0) ? len_in_s : len_r;
    assign last_byte_s = ((byte_idx_r + 2'd1) == eff_len_s);

    assign raw_opcode  = opcode_cycle_s ? mem_data_in : opcode_r;

    // Outputs decoded straight from registered state; the read strobe is
    // also masked by reset so no read is issued while reset is held.
    assign mem_addr    = pc_r;
    assign mem_rd_en   = (state_r == ST_ADDR) && !reset;
    assign instr_valid = (state_r == ST_VALID);
    assign halted      = (state_r == ST_HALT);
    assign opcode      = opcode_r;
    assign operand_lo  = operand_lo_r;
    assign operand_hi  = operand_hi_r;
    assign target_addr = {operand_hi_r, operand_lo_r};
    assign next_pc     = pc_r;

    // Fetch state machine: priority is reset > halt > redirect > handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_ADDR;
            pc_r         <= RESET_VECTOR;
            byte_idx_r   <= 2'd0;
            len_r        <= 2'd1;
            opcode_r     <= 8'h00;
            operand_lo_r <= 8'h00;
            operand_hi_r <= 8'h00;
        end else if (halt_req || (state_r == ST_HALT)) begin
            // HALT freezes the pc and all instruction bytes.
            state_r <= ST_HALT;
        end else if (pc_load) begin
            // Redirect drops any partially assembled instruction; a pending
            // handshake in VALID is simply completed by leaving VALID.
            state_r      <= ST_ADDR;
            pc_r         <= pc_load_addr;
            byte_idx_r   <= 2'd0;
            opcode_r     <= 8'h00;
            operand_lo_r <= 8'h00;
            operand_hi_r <= 8'h00;
        end else begin
            case (state_r)
                ST_ADDR: begin
                    state_r <= ST_DATA;
                end
                ST_DATA: begin
                    case (byte_idx_r)
                        2'd0: begin
                            // New instruction: operands not fetched read as 0.
                            opcode_r     <= mem_data_in;
                            operand_lo_r <= 8'h00;
                            operand_hi_r <= 8'h00;
                            len_r        <= len_in_s;
                        end
                        2'd1: begin
                            operand_lo_r <= mem_data_in;
                        end
                        default: begin
                            operand_hi_r <= mem_data_in;
                        end
                    endcase
                    pc_r       <= pc_r + 16'd1;
                    byte_idx_r <= byte_idx_r + 2'd1;
                    state_r    <= last_byte_s ? ST_VALID : ST_ADDR;
                end
                ST_VALID: begin
                    if (instr_ready) begin
                        byte_idx_r <= 2'd0;
                        state_r    <= ST_ADDR;
                    end else begin
                        state_r <= ST_VALID;
                    end
                end
                default: begin
                    state_r <= ST_ADDR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Drives instr_fetch_unit with a byte-wide memory model and a table-driven
// decoder. Directed scenarios cover the reset vector, latency, stalls,
// redirects, HALT, address wrap and reset during a fetch. A random phase
// checks each instruction against a transaction-level model. In that model an
// instruction at address S has length L = dec(mem[S]), where 0 counts as 1.
// Its bytes are mem[S..S+L-1], with zeros in slots that are not fetched.
// next_pc is S+L, and the instruction shows up 2*L cycles after the fetch
// restarts.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_data_in;
    logic [7:0]  raw_opcode;
    logic [1:0]  op_len;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  opcode;
    logic [7:0]  operand_lo;
    logic [7:0]  operand_hi;
    logic [15:0] target_addr;
    logic [15:0] next_pc;
    logic        pc_load;
    logic [15:0] pc_load_addr;
    logic        halt_req;
    logic        halted;

    logic [7:0]  mem [65536];
    logic [1:0]  dec_tab [256];

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch_unit #(.RESET_VECTOR(16'hF000)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_data_in  (mem_data_in),
        .raw_opcode   (raw_opcode),
        .op_len       (op_len),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .opcode       (opcode),
        .operand_lo   (operand_lo),
        .operand_hi   (operand_hi),
        .target_addr  (target_addr),
        .next_pc      (next_pc),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
        .halt_req     (halt_req),
        .halted       (halted)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decoder model: combinational length lookup for the presented opcode.
    assign op_len = dec_tab[raw_opcode];

    // Memory model: one-cycle read latency, garbage when not reading.
    always @(posedge clk) begin
        if (mem_rd_en) mem_data_in <= mem[mem_addr];
        else           mem_data_in <= 8'($urandom);
    end

    // Single comparison point for the whole bench.
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int eff_len(input logic [15:0] s);
        int l;
        l = int'(dec_tab[mem[s]]);
        return (l == 0) ? 1 : l;
    endfunction

    // Wait (from a negedge) for instr_valid, counting negedges; bounded.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!instr_valid && cyc < 40);
        if (!instr_valid) chk("valid_timeout", 32'(cyc), 32'd0);
    endtask

    // Hold reset two cycles, check reset state, release at a negedge.
    task automatic do_reset();
        reset = 1'b1; pc_load = 1'b0; halt_req = 1'b0; instr_ready = 1'b1;
        pc_load_addr = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_valid",  32'(instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_rd_en",  32'(mem_rd_en), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_addr",   32'(mem_addr), 32'hF000);
        reset = 1'b0;
        #1;
        chk("post_rst_addr", 32'(mem_addr), 32'hF000);
        chk("post_rst_rd",   32'(mem_rd_en), 32'd1);
    endtask

    initial begin
        int cyc;
        logic [15:0] s;
        logic [15:0] a;
        int L;
        int rd_cnt;
        int idle_cnt;
        int n_instr;
        logic hs;

        reset = 1'b1; pc_load = 1'b0; halt_req = 1'b0; instr_ready = 1'b0;
        pc_load_addr = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) dec_tab[i] = 2'($urandom);
        // Directed program and decoder entries.
        dec_tab[8'h3E] = 2'd2;  // LDI_A
        dec_tab[8'h00] = 2'd0;  // length 0, taken as 1
        dec_tab[8'h01] = 2'd1;  // NOP
        dec_tab[8'hCA] = 2'd3;  // JZ
        dec_tab[8'h76] = 2'd1;  // HLT
        mem[16'hF000] = 8'h3E; mem[16'hF001] = 8'h00;
        mem[16'hF002] = 8'h00; mem[16'hF003] = 8'h01;
        mem[16'hF004] = 8'hCA; mem[16'hF005] = 8'h0C; mem[16'hF006] = 8'hF0;
        mem[16'hF00E] = 8'h76;
        mem[16'hFFFF] = 8'h01;

        // ---- Straight-line program from the reset vector ----
        do_reset();
        wait_valid(cyc);
        chk("ldi_latency", 32'(cyc), 32'd4);
        chk("ldi_opcode",  32'(opcode), 32'h3E);
        chk("ldi_lo",      32'(operand_lo), 32'h00);
        chk("ldi_hi",      32'(operand_hi), 32'h00);
        chk("ldi_next_pc", 32'(next_pc), 32'hF002);
        wait_valid(cyc);
        chk("len0_latency", 32'(cyc), 32'd3);
        chk("len0_next_pc", 32'(next_pc), 32'hF003);
        chk("len0_lo",      32'(operand_lo), 32'h00);
        wait_valid(cyc);
        chk("nop_next_pc", 32'(next_pc), 32'hF004);
        wait_valid(cyc);
        instr_ready = 1'b0;
        chk("jz_latency", 32'(cyc), 32'd7);
        chk("jz_opcode",  32'(opcode), 32'hCA);
        chk("jz_lo",      32'(operand_lo), 32'h0C);
        chk("jz_hi",      32'(operand_hi), 32'hF0);
        chk("jz_target",  32'(target_addr), 32'hF00C);
        chk("jz_next_pc", 32'(next_pc), 32'hF007);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid",  32'(instr_valid), 32'd1);
            chk("stall_rd_en",  32'(mem_rd_en), 32'd0);
            chk("stall_target", 32'(target_addr), 32'hF00C);
            chk("stall_opcode", 32'(opcode), 32'hCA);
            chk("stall_next",   32'(next_pc), 32'hF007);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        chk("release_valid", 32'(instr_valid), 32'd0);
        chk("release_rd",    32'(mem_rd_en), 32'd1);
        chk("release_addr",  32'(mem_addr), 32'hF007);

        // ---- Redirect during the second byte, then HALT ----
        do_reset();
        repeat (3) @(negedge clk);          // now in DATA of byte 2
        pc_load = 1'b1; pc_load_addr = 16'hF00E;
        @(negedge clk);
        pc_load = 1'b0;
        chk("redir_rd",     32'(mem_rd_en), 32'd1);
        chk("redir_addr",   32'(mem_addr), 32'hF00E);
        chk("redir_valid",  32'(instr_valid), 32'd0);
        chk("redir_opcode", 32'(opcode), 32'h00);
        wait_valid(cyc);
        chk("hlt_latency", 32'(cyc), 32'd2);
        chk("hlt_opcode",  32'(opcode), 32'h76);
        chk("hlt_lo",      32'(operand_lo), 32'h00);
        chk("hlt_next_pc", 32'(next_pc), 32'hF00F);
        instr_ready = 1'b0;
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        instr_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pc_load = (i == 3);             // redirect must be ignored in HALT
            pc_load_addr = 16'h1234;
            @(negedge clk);
            chk("halt_flag",  32'(halted), 32'd1);
            chk("halt_rd_en", 32'(mem_rd_en), 32'd0);
            chk("halt_valid", 32'(instr_valid), 32'd0);
            chk("halt_pc",    32'(next_pc), 32'hF00F);
        end
        pc_load = 1'b0;

        // ---- 1-byte instruction at FFFF wraps to 0000 ----
        do_reset();
        pc_load = 1'b1; pc_load_addr = 16'hFFFF;
        @(negedge clk);
        pc_load = 1'b0;
        chk("wrap_addr", 32'(mem_addr), 32'hFFFF);
        wait_valid(cyc);
        chk("wrap_next_pc", 32'(next_pc), 32'h0000);
        @(negedge clk);
        chk("wrap_fetch_addr", 32'(mem_addr), 32'h0000);
        chk("wrap_fetch_rd",   32'(mem_rd_en), 32'd1);

        // ---- Reset in the middle of a 3-byte fetch ----
        do_reset();
        pc_load = 1'b1; pc_load_addr = 16'hF004;
        @(negedge clk);
        pc_load = 1'b0;
        repeat (3) @(negedge clk);          // DATA of byte 2 of JZ
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_valid",  32'(instr_valid), 32'd0);
        chk("midrst_opcode", 32'(opcode), 32'h00);
        chk("midrst_lo",     32'(operand_lo), 32'h00);
        chk("midrst_rd",     32'(mem_rd_en), 32'd0);
        reset = 1'b0;
        #1;
        chk("midrst_addr", 32'(mem_addr), 32'hF000);
        chk("midrst_rd2",  32'(mem_rd_en), 32'd1);

        // ---- Random phase against the transaction-level model ----
        do_reset();
        s = 16'($urandom);
        pc_load = 1'b1; pc_load_addr = s;
        rd_cnt = 0; idle_cnt = 0; n_instr = 0;
        for (int it = 0; it < 4000; it++) begin
            @(negedge clk);
            L = eff_len(s);
            if (mem_rd_en) begin
                a = s + 16'(rd_cnt);
                chk("rnd_rd_addr", 32'(mem_addr), 32'(a));
                rd_cnt++;
            end
            if (instr_valid) begin
                a = s + 16'd1;
                chk("rnd_reads",   32'(rd_cnt), 32'(L));
                chk("rnd_latency", 32'(idle_cnt), 32'(2 * L));
                chk("rnd_opcode",  32'(opcode), 32'(mem[s]));
                chk("rnd_lo",      32'(operand_lo), (L > 1) ? 32'(mem[a]) : 32'd0);
                a = s + 16'd2;
                chk("rnd_hi",      32'(operand_hi), (L > 2) ? 32'(mem[a]) : 32'd0);
                chk("rnd_target",  32'(target_addr), 32'({operand_hi, operand_lo}));
                chk("rnd_next_pc", 32'(next_pc), 32'(s + 16'(L)));
            end else begin
                idle_cnt++;
                if (idle_cnt > 12) begin
                    chk("rnd_timeout", 32'(idle_cnt), 32'd0);
                    break;
                end
            end
            // Next-cycle stimulus and model update.
            instr_ready  = ($urandom_range(2) != 0);
            pc_load      = ($urandom_range(39) == 0);
            pc_load_addr = 16'($urandom);
            hs = instr_valid && instr_ready;
            if (pc_load) begin
                s = pc_load_addr; rd_cnt = 0; idle_cnt = 0;
            end else if (hs) begin
                s = s + 16'(L); rd_cnt = 0; idle_cnt = 0;
                n_instr++;
            end
        end
        pc_load = 1'b0;
        chk("rnd_progress", 32'(n_instr > 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 16'hF000, is the PC value loaded on reset (ROM base).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mem_addr  output  16  byte address driven to ROM/RAM.
REQ-005 mem_rd_en  output  1  read strobe; memory returns data one cycle later.
REQ-006 mem_data_in  input  8  read data, valid the cycle after mem_rd_en.
REQ-007 raw_opcode  output  8  opcode byte held for the decoder.
REQ-008 op_len  input  2  instruction length in bytes (1..3) returned combinationally by the decoder for raw_opcode.
REQ-009 instr_valid  output  1  assembled instruction available.
REQ-010 instr_ready  input  1  execute stage accepts the instruction.
REQ-011 opcode, operand_lo, operand_hi  output  8 each  assembled instruction bytes.
REQ-012 target_addr  output  16  {operand_hi, operand_lo}.
REQ-013 next_pc  output  16  address of the byte following the assembled instruction.
REQ-014 pc_load  input  1  one-cycle branch/jump redirect request.
REQ-015 pc_load_addr  input  16  redirect address.
REQ-016 halt_req  input  1  stop fetching (HLT executed).
REQ-017 halted  output  1  block is in HALT state.

Function
REQ-018 States SHALL be ADDR, DATA, VALID, HALT.
REQ-019 ADDR: mem_addr = pc, mem_rd_en = 1; next state DATA.
REQ-020 DATA: capture mem_data_in into byte slot byte_idx (0 = opcode, 1 = operand_lo, 2 = operand_hi), pc <= pc + 1, byte_idx++.
REQ-021 In DATA with byte_idx = 0, length SHALL be latched from op_len (raw_opcode = mem_data_in combinationally that cycle); op_len = 0 SHALL be treated as 1.
REQ-022 DATA -> ADDR while bytes remain; DATA -> VALID after the final byte.
REQ-023 Unfetched operand slots SHALL read 8'h00.
REQ-024 Latency: 1-byte instruction instr_valid 2 cycles after entering ADDR; 2-byte 4 cycles; 3-byte 6 cycles.
REQ-025 VALID: instr_valid = 1 and all instruction outputs SHALL be stable until instr_valid & instr_ready; on handshake, byte_idx <= 0 and next state ADDR.
REQ-026 next_pc SHALL equal pc in VALID (start address + length).
REQ-027 PC arithmetic is 16-bit modulo: 16'hFFFF + 1 = 16'h0000.
REQ-028 pc_load in any non-HALT state: pc <= pc_load_addr, byte_idx <= 0, partially assembled bytes discarded, next state ADDR, instr_valid = 0 the following cycle.
REQ-029 pc_load coincident with a VALID handshake: handshake completes, and the redirect takes effect.
REQ-030 halt_req in any state: next state HALT; priority halt_req > pc_load > handshake.
REQ-031 HALT: mem_rd_en = 0, instr_valid = 0, halted = 1, PC frozen; exited only by reset.
REQ-032 mem_rd_en SHALL be 0 in DATA, VALID and HALT.

Reset
REQ-033 On reset: state ADDR, pc = RESET_VECTOR, byte_idx = 0, opcode/operand_lo/operand_hi = 8'h00, instr_valid = 0, halted = 0, mem_rd_en = 0 during the reset cycle.
REQ-034 Reset mid-fetch or in HALT SHALL abandon the instruction; first post-reset ADDR cycle drives mem_addr = RESET_VECTOR.

Verification
REQ-035 ROM F000: LDI_A (len 2), 00; instr_ready = 1 -> instr_valid 4 cycles after reset release, opcode = LDI_A, operand_lo = 00, operand_hi = 00, next_pc = F002.
REQ-036 ROM F004: JZ (len 3), 0C, F0 -> operand_lo = 0C, operand_hi = F0, target_addr = F00C, next_pc = F007, 6 cycles ADDR-to-valid.
REQ-037 instr_ready held 0 for 5 cycles in VALID -> outputs unchanged, no mem_rd_en; release -> next ADDR drives next_pc.
REQ-038 pc_load = 1, pc_load_addr = F00E during DATA of byte 2 -> next cycle ADDR, mem_addr = F00E, partial bytes dropped; HLT at F00E then halt_req -> halted = 1, mem_rd_en stays 0 for 10 cycles.
REQ-039 1-byte opcode at FFFF -> next_pc = 0000, next fetch mem_addr = 0000; op_len = 0 -> treated as length 1.
REQ-040 reset asserted in DATA of a 3-byte fetch -> instr_valid = 0, opcode = 00, next mem_addr = F000.
